// File: rtl/ccsds_tx_pkg.sv
// Shared types and helpers for the CCSDS TX frame scheduler.
package ccsds_tx_pkg;

  localparam int CCSDS_MAX_VC = 8;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LAUNCH, S_WAIT} sched_state_t;

  // One-hot of a VC index, sized for the largest supported VC count.
  function automatic logic [CCSDS_MAX_VC-1:0] vc_onehot(input logic [2:0] idx);
    vc_onehot      = '0;
    vc_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/ccsds_tx_frame_scheduler_if.sv
// VC-source and engine-side signals of the frame scheduler.
interface ccsds_tx_frame_scheduler_if #(
  parameter int NUM_VC     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                         enable;
  logic [NUM_VC-1:0]            vc_req;
  logic [NUM_VC*ADDR_WIDTH-1:0] vc_addr;
  logic [NUM_VC*LEN_WIDTH-1:0]  vc_len;
  logic [NUM_VC-1:0]            vc_grant;
  logic [NUM_VC-1:0]            vc_done;
  logic [NUM_VC-1:0]            vc_err;
  logic                         txn_init;
  logic [ADDR_WIDTH-1:0]        txn_addr;
  logic [LEN_WIDTH-1:0]         txn_len;
  logic                         txn_done;
  logic                         txn_error;
  logic                         busy;
  logic [$clog2(NUM_VC)-1:0]    cur_vc;
  logic                         timeout_flag;
  logic [31:0]                  frame_cnt;
  logic [15:0]                  err_cnt;

  // Scheduler side.
  modport master (
    input  enable, vc_req, vc_addr, vc_len, txn_done, txn_error,
    output vc_grant, vc_done, vc_err, txn_init, txn_addr, txn_len,
           busy, cur_vc, timeout_flag, frame_cnt, err_cnt
  );

  // VC sources / engine / status consumer side.
  modport slave (
    output enable, vc_req, vc_addr, vc_len, txn_done, txn_error,
    input  vc_grant, vc_done, vc_err, txn_init, txn_addr, txn_len,
           busy, cur_vc, timeout_flag, frame_cnt, err_cnt
  );
endinterface

// File: rtl/ccsds_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr, wrapping.
module ccsds_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 valid
);

  // Scan farthest-to-nearest so the nearest requester is the last one written.
  always_comb begin
    gnt_idx = '0;
    valid   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt_idx = ($clog2(N))'((int'(ptr) + i) % N);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccsds_tx_frame_scheduler.sv
// Shares the CCSDS TX AXI master engine between NUM_VC frame sources:
// round-robin arbitration, engine launch, completion/timeout and statistics.
module ccsds_tx_frame_scheduler
  import ccsds_tx_pkg::*;
#(
  parameter int NUM_VC         = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                        ACLK,
  input logic                        ARESET,
  ccsds_tx_frame_scheduler_if.master bus
);

  localparam int VW = $clog2(NUM_VC);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_t          state;
  logic [VW-1:0]         rr_ptr;
  logic [VW-1:0]         win_idx;
  logic                  win_vld;
  logic [VW-1:0]         nxt_ptr;
  logic [TW-1:0]         tcnt;
  logic                  done_q;
  logic                  done_edge;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic [NUM_VC-1:0]     cur_oh;

  ccsds_rr_arbiter #(.N(NUM_VC)) u_arb (
    .req     (bus.vc_req),
    .ptr     (rr_ptr),
    .gnt_idx (win_idx),
    .valid   (win_vld)
  );

  assign addr_sel  = bus.vc_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign len_sel   = bus.vc_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign cur_oh    = NUM_VC'(vc_onehot(3'(bus.cur_vc)));
  assign nxt_ptr   = (int'(bus.cur_vc) == NUM_VC - 1) ? '0 : bus.cur_vc + 1'b1;
  // A done level left over from the previous frame must not complete the next one.
  assign done_edge = bus.txn_done & ~done_q;
  assign bus.busy  = (state != S_IDLE);

  // Engine done history, tracked every cycle regardless of state.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) done_q <= 1'b0;
    else        done_q <= bus.txn_done;
  end

  // Scheduler FSM with registered pulses, latched frame and saturating stats.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      tcnt             <= '0;
      bus.cur_vc       <= '0;
      bus.txn_addr     <= '0;
      bus.txn_len      <= '0;
      bus.vc_grant     <= '0;
      bus.vc_done      <= '0;
      bus.vc_err       <= '0;
      bus.txn_init     <= 1'b0;
      bus.timeout_flag <= 1'b0;
      bus.frame_cnt    <= '0;
      bus.err_cnt      <= '0;
    end else begin
      bus.vc_grant <= '0;
      bus.vc_done  <= '0;
      bus.vc_err   <= '0;
      bus.txn_init <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.enable && win_vld) begin
            bus.cur_vc   <= win_idx;
            bus.txn_addr <= addr_sel;
            bus.txn_len  <= len_sel;
            bus.vc_grant <= NUM_VC'(vc_onehot(3'(win_idx)));
            state        <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Empty frames complete without touching the engine or the stats.
          if (bus.txn_len == '0) begin
            bus.vc_done <= cur_oh;
            state       <= S_IDLE;
          end else begin
            bus.txn_init <= 1'b1;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done edge in the last timeout cycle still counts as completion.
          if (done_edge) begin
            if (bus.txn_error) begin
              bus.vc_err <= cur_oh;
              if (bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + 1'b1;
            end else begin
              bus.vc_done <= cur_oh;
              if (bus.frame_cnt != '1) bus.frame_cnt <= bus.frame_cnt + 1'b1;
            end
            rr_ptr <= nxt_ptr;
            state  <= S_IDLE;
          end else if (tcnt == T_LAST) begin
            bus.vc_err       <= cur_oh;
            bus.timeout_flag <= 1'b1;
            if (bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + 1'b1;
            rr_ptr <= nxt_ptr;
            state  <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
